// File: rtl/minimips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : minimips_pkg
// Brief   : Shared encodings for the MiniMIPS multi-cycle control path.
// Revision: 1.0 - initial release
// ============================================================================
package minimips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WR = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [3:0] c_OP_RTYPE = 4'h0;
  localparam logic [3:0] c_OP_ADDI  = 4'h1;
  localparam logic [3:0] c_OP_ANDI  = 4'h2;
  localparam logic [3:0] c_OP_ORI   = 4'h3;
  localparam logic [3:0] c_OP_NORI  = 4'h4;
  localparam logic [3:0] c_OP_SLTI  = 4'h5;
  localparam logic [3:0] c_OP_LW    = 4'h6;
  localparam logic [3:0] c_OP_SW    = 4'h7;
  localparam logic [3:0] c_OP_BEQ   = 4'h8;
  localparam logic [3:0] c_OP_BNE   = 4'h9;
  localparam logic [3:0] c_OP_J     = 4'hA;
  localparam logic [3:0] c_OP_JAL   = 4'hB;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  localparam logic [2:0] c_ALU_ADD   = 3'b000;
  localparam logic [2:0] c_ALU_SUB   = 3'b001;
  localparam logic [2:0] c_ALU_AND   = 3'b010;
  localparam logic [2:0] c_ALU_OR    = 3'b011;
  localparam logic [2:0] c_ALU_NOR   = 3'b100;
  localparam logic [2:0] c_ALU_SLT   = 3'b101;
  localparam logic [2:0] c_ALU_FUNCT = 3'b110;

  localparam logic [1:0] c_PC_SEQ    = 2'b00;
  localparam logic [1:0] c_PC_BRANCH = 2'b01;
  localparam logic [1:0] c_PC_JUMP   = 2'b10;

  localparam logic [1:0] c_DST_RT = 2'b00;
  localparam logic [1:0] c_DST_RD = 2'b01;
  localparam logic [1:0] c_DST_RA = 2'b10;

  localparam logic [1:0] c_M2R_ALU = 2'b00;
  localparam logic [1:0] c_M2R_MEM = 2'b01;
  localparam logic [1:0] c_M2R_PC  = 2'b10;

  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      c_OP_ANDI: return c_ALU_AND;
      c_OP_ORI:  return c_ALU_OR;
      c_OP_NORI: return c_ALU_NOR;
      c_OP_SLTI: return c_ALU_SLT;
      default:   return c_ALU_ADD;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/minimips_mem_waiter.sv
`default_nettype none
// ============================================================================
// Module  : minimips_mem_waiter
// Brief   : Data-memory wait counter with ready/timeout resolution.
// Revision: 1.0 - initial release
// ============================================================================
module minimips_mem_waiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_done,
  output logic o_timeout
);

  localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

  logic [7:0] r_cnt;

  // Once MAX_WAIT idle cycles have elapsed the access is abandoned, even if
  // ready shows up in that same cycle.
  assign o_timeout = i_active && (r_cnt == c_MAX_WAIT);
  assign o_done    = i_active && i_mem_ready && !o_timeout;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_active && !i_mem_ready && !o_timeout) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/minimips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : minimips_multicycle_ctrl
// Brief   : Multi-cycle control FSM driving the MiniMIPS datapath.
// Revision: 1.0 - initial release
// ============================================================================
module minimips_multicycle_ctrl
  import minimips_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_b,
  output logic             imm_zext,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state_out
);

  state_t           r_state;
  state_t           w_next;
  logic             r_bus_error;
  logic [CNT_W-1:0] r_retired;
  logic             w_mem_active;
  logic             w_mem_done;
  logic             w_mem_timeout;
  logic             w_retire;
  logic             w_reserved;
  logic             w_take;
  logic             w_funct_unused;

  // The datapath decodes funct itself under the passthrough ALU op.
  assign w_funct_unused = ^funct;

  assign w_reserved   = is_reserved(opcode);
  assign w_mem_active = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_take       = ((opcode == c_OP_BEQ) && zero) || ((opcode == c_OP_BNE) && !zero);

  minimips_mem_waiter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_waiter (
    .clk         (clk),
    .rst         (reset),
    .i_clear     (r_state == S_ADDR),
    .i_active    (w_mem_active),
    .i_mem_ready (mem_ready),
    .o_done      (w_mem_done),
    .o_timeout   (w_mem_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_bus_error <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_state <= w_next;
      if (w_mem_timeout) r_bus_error <= 1'b1;
      if (w_retire)      r_retired   <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE:                                        w_next = S_EXEC_R;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_NORI, c_OP_SLTI: w_next = S_EXEC_I;
          c_OP_LW, c_OP_SW:                                  w_next = S_ADDR;
          c_OP_BEQ, c_OP_BNE:                                w_next = S_BRANCH;
          c_OP_J, c_OP_JAL:                                  w_next = S_JUMP;
          c_OP_HALT:                                         w_next = S_HALT;
          default:                                           w_next = S_FETCH;
        endcase
      end
      S_EXEC_R: w_next = S_WB_R;
      S_WB_R:   w_next = S_FETCH;
      S_EXEC_I: w_next = S_WB_I;
      S_WB_I:   w_next = S_FETCH;
      S_ADDR:   w_next = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (w_mem_timeout)   w_next = S_HALT;
        else if (w_mem_done) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (w_mem_timeout)   w_next = S_HALT;
        else if (w_mem_done) w_next = S_FETCH;
      end
      S_WB_MEM: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  // Retirement is flagged on each instruction's last cycle, so the count
  // becomes visible in the following FETCH.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WR: w_retire = w_mem_done;
      S_DECODE: w_retire = w_reserved;
      default:  w_retire = 1'b0;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = c_PC_SEQ;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = c_DST_RT;
    mem_to_reg = c_M2R_ALU;
    alu_src_b  = 1'b0;
    imm_zext   = 1'b0;
    alu_op     = c_ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: illegal = w_reserved;
      S_EXEC_R, S_WB_R: begin
        alu_op    = c_ALU_FUNCT;
        reg_write = (r_state == S_WB_R);
        reg_dst   = c_DST_RD;
      end
      S_EXEC_I, S_WB_I: begin
        alu_src_b = 1'b1;
        alu_op    = imm_alu_op(opcode);
        imm_zext  = (opcode == c_OP_ANDI) || (opcode == c_OP_ORI) || (opcode == c_OP_NORI);
        reg_write = (r_state == S_WB_I);
      end
      S_ADDR, S_MEM_RD, S_MEM_WR: begin
        alu_src_b = 1'b1;
        mem_read  = (r_state == S_MEM_RD) && !w_mem_timeout;
        mem_write = (r_state == S_MEM_WR) && !w_mem_timeout;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = c_M2R_MEM;
      end
      S_BRANCH: begin
        alu_op   = c_ALU_SUB;
        pc_write = w_take;
        pc_src   = w_take ? c_PC_BRANCH : c_PC_SEQ;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = c_PC_JUMP;
        if (opcode == c_OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = c_DST_RA;
          mem_to_reg = c_M2R_PC;
        end
      end
      default: ;
    endcase
  end

  assign halted        = (r_state == S_HALT);
  assign bus_error     = r_bus_error;
  assign retired_count = r_retired;
  assign state_out     = r_state;

endmodule
`default_nettype wire

// File: doc/minimips_multicycle_ctrl.md
Name: minimips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the 16-bit MiniMIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives all datapath enables and mux selects. It handles the data-memory ready handshake and timeout, halt and illegal-opcode handling, and a retired-instruction counter. It sits beside the register file, ALU and data memory inside MiniMIPS, and replaces the single-cycle decoder.

Parameters:
MAX_WAIT, 15, max cycles a memory access waits for mem_ready before bus error (1..255)
CNT_W, 32, width of retired_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  4  IR[15:12], valid from DECODE onward
funct  input  3  IR[2:0], R-type ALU function
zero  input  1  ALU zero flag, combinational from current ALU operands
mem_ready  input  1  data memory access complete
pc_write  output  1  load PC this edge
pc_src  output  2  00 PC+1, 01 PC+sext(imm), 10 jump target
ir_write  output  1  latch instruction into IR
reg_write  output  1  register-file write enable
reg_dst  output  2  00 rt, 01 rd, 10 $ra (reg 7)
mem_to_reg  output  2  00 ALU result, 01 memory data, 10 PC
alu_src_b  output  1  0 register rt, 1 immediate
imm_zext  output  1  1 zero-extend immediate, 0 sign-extend
alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 nor, 101 slt, 110 funct passthrough
mem_read  output  1  data memory read strobe
mem_write  output  1  data memory write strobe
halted  output  1  sticky, FSM in HALT
bus_error  output  1  sticky, memory timeout occurred
illegal  output  1  one-cycle pulse, reserved opcode decoded
retired_count  output  CNT_W  instructions completed
state_out  output  4  current state encoding, for debug

Behaviour:
- Reset: state FETCH (0). All strobes, enables and selects 0. halted=0, bus_error=0, retired_count=0, wait counter 0. Reset in any state, including mid memory wait, takes effect at the next edge with no write issued.
- All outputs except counters and sticky flags are Moore, decoded from state, opcode, funct and zero.
- Opcode map: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 nori, 0101 slti, 0110 lw, 0111 sw, 1000 beq, 1001 bne, 1010 j, 1011 jal, 1100-1110 reserved, 1111 halt.
- FETCH (0): ir_write=1, pc_write=1, pc_src=00 -> DECODE.
- DECODE (1): no strobes. Next state by opcode: R -> EXEC_R; addi/andi/ori/nori/slti -> EXEC_I; lw/sw -> ADDR; beq/bne -> BRANCH; j/jal -> JUMP; reserved -> FETCH with illegal=1 for one cycle and retired_count+1 (treated as NOP); halt -> HALT.
- EXEC_R (2): alu_op=110, alu_src_b=0 -> WB_R (3). WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, alu_op held -> FETCH.
- EXEC_I (4): alu_src_b=1, alu_op per opcode (add, and, or, nor, slt). imm_zext=1 for andi/ori/nori, else 0 -> WB_I (5). WB_I: reg_write=1, reg_dst=00, mem_to_reg=00, ALU controls held -> FETCH.
- ADDR (6): alu_op=000, alu_src_b=1, imm_zext=0. Goes to MEM_RD (7) for lw, MEM_WR (8) for sw. The wait counter is cleared.
- MEM_RD/MEM_WR: mem_read or mem_write held high with address controls held. The wait counter increments each cycle mem_ready=0.
  - mem_ready=1: lw -> WB_MEM (9); sw -> FETCH with retired_count+1.
  - mem_ready=1 in the first MEM cycle is valid, giving zero wait states.
  - Counter reaching MAX_WAIT with mem_ready still 0: strobe drops, bus_error=1 -> HALT.
- WB_MEM (9): reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- BRANCH (10): alu_op=001, alu_src_b=0. pc_write=1 and pc_src=01 iff (beq and zero) or (bne and !zero) -> FETCH.
- JUMP (11): pc_write=1, pc_src=10. jal also asserts reg_write=1, reg_dst=10, mem_to_reg=10; the value written is PC, already incremented -> FETCH.
- HALT (12): all strobes 0, halted=1, remains until reset.
- retired_count increments by 1 on the final cycle of every instruction: WB_R, WB_I, WB_MEM, BRANCH, JUMP, sw completion, and reserved NOP. It wraps modulo 2^CNT_W. It does not count halt or timed-out accesses.
- Latencies: R/I 4 cycles, beq/bne/j/jal 3 cycles, lw 5+W cycles, sw 4+W cycles (W = wait cycles).
- Unused encodings 13-15 -> HALT with bus_error unchanged (defensive).

Decomposition:
- Package minimips_pkg: opcode localparams, state encoding, alu_op codes, pc_src/reg_dst/mem_to_reg codes. These are shared with the datapath and testbench.
- One sub-module, minimips_mem_waiter: wait counter, timeout compare and done/timeout outputs, instantiated for MEM_RD/MEM_WR. The FSM and output decode stay in the top module.

Test Plan:
- add (0000, funct=000) after reset -> states 0,1,2,3,0; WB_R reg_write=1 reg_dst=01 alu_op=110; retired_count=1 after 4 cycles.
- lw with mem_ready low for 3 cycles -> mem_read high 4 cycles, WB_MEM mem_to_reg=01, total 8 cycles; sw with mem_ready high immediately -> 4 cycles, mem_write exactly 1 cycle.
- beq with zero=1 -> BRANCH pc_write=1 pc_src=01; with zero=0 -> pc_write=0; bne inverted; retired_count increments in both cases.
- jal -> JUMP pc_write=1 pc_src=10 reg_write=1 reg_dst=10 mem_to_reg=10, 3 cycles.
- lw with mem_ready never asserted, MAX_WAIT=15 -> mem_read drops after 15 wait cycles, bus_error=1, halted=1 next cycle, retired_count unchanged; opcode 1100 -> illegal pulse, back to FETCH, count+1.
- reset asserted during MEM_WR wait -> next edge state 0, mem_write=0, retired_count=0; opcode 1111 -> HALT, halted stays 1 for 100 cycles until reset.
